// File: rtl/framebuffer_clear_engine.sv
// Framebuffer clear engine: on a start pulse, streams one replicated-colour fill word
// per accepted beat across the whole framebuffer, then pulses clear_done.
`timescale 1ns/1ps
module framebuffer_clear_engine #(
  parameter int                FB_WIDTH     = 320,
  parameter int                FB_HEIGHT    = 240,
  parameter int                PIXEL_W      = 16,
  parameter int                PIX_PER_WORD = 2,
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear_start,
  input  logic [PIXEL_W-1:0]              clear_color,
  output logic                            clear_done,
  output logic                            busy,
  output logic                            fb_wr_valid,
  input  logic                            fb_wr_ready,
  output logic [ADDR_W-1:0]               fb_wr_addr,
  output logic [PIXEL_W*PIX_PER_WORD-1:0] fb_wr_data,
  output logic                            fb_wr_last
);

  localparam int NUM_WORDS = FB_WIDTH * FB_HEIGHT / PIX_PER_WORD;
  localparam int STRIDE    = PIXEL_W * PIX_PER_WORD / 8;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);

  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(STRIDE);

  if ((FB_WIDTH * FB_HEIGHT) % PIX_PER_WORD != 0) begin : g_bad_geometry
    $error("FB_WIDTH*FB_HEIGHT must be divisible by PIX_PER_WORD");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ADDR_W-1:0]    addr_q,  addr_d;
  logic [PIXEL_W-1:0]   color_q, color_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      addr_q  <= BASE_ADDR;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      color_q <= color_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    color_d = color_q;
    unique case (state_q)
      S_IDLE: begin
        if (clear_start) begin
          color_d = clear_color;
          addr_d  = BASE_ADDR;
          count_d = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (fb_wr_ready) begin
          addr_d  = addr_q + STEP;
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_CNT) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All outputs decode straight from registered state, so reset clears them without a clock edge.
  always_comb begin
    fb_wr_valid = (state_q == S_WRITE);
    fb_wr_last  = (state_q == S_WRITE) && (count_q == LAST_CNT);
    clear_done  = (state_q == S_DONE);
    busy        = (state_q != S_IDLE);
    fb_wr_addr  = addr_q;
    fb_wr_data  = {PIX_PER_WORD{color_q}};
  end

endmodule

// File: tb/tb_framebuffer_clear_engine.sv
// Scoreboard bench for framebuffer_clear_engine: a small 4x2 instance under random
// backpressure and start pulses, plus a default-size instance for the full-frame run.
`timescale 1ns/1ps
module tb_framebuffer_clear_engine;

  localparam int N      = 4;
  localparam int STRIDE = 4;
  localparam int BIG_N  = 38400;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_start, clear_done, busy, fb_wr_valid, fb_wr_ready, fb_wr_last;
  logic [15:0] clear_color;
  logic [31:0] fb_wr_addr, fb_wr_data;

  logic        b_start, b_done, b_busy, b_valid, b_ready, b_last;
  logic [15:0] b_color;
  logic [31:0] b_addr, b_data;

  always #5 clk = ~clk;

  framebuffer_clear_engine #(
    .FB_WIDTH(4), .FB_HEIGHT(2), .PIXEL_W(16), .PIX_PER_WORD(2), .ADDR_W(32), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .clear_start(clear_start), .clear_color(clear_color),
    .clear_done(clear_done), .busy(busy), .fb_wr_valid(fb_wr_valid), .fb_wr_ready(fb_wr_ready),
    .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data), .fb_wr_last(fb_wr_last)
  );

  framebuffer_clear_engine dut_big (
    .clk(clk), .rst(rst), .clear_start(b_start), .clear_color(b_color),
    .clear_done(b_done), .busy(b_busy), .fb_wr_valid(b_valid), .fb_wr_ready(b_ready),
    .fb_wr_addr(b_addr), .fb_wr_data(b_data), .fb_wr_last(b_last)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a clear accepted while idle expands into N beats of
  // {colour,colour} at BASE + i*STRIDE; done is due one cycle after the last handshake.
  beat_t exp_q[$];
  int    done_q[$];
  int    acc_cyc, done_cyc, done_cnt;
  bit    idle;
  beat_t fr;

  always @(negedge clk) begin
    if (!rst) begin
      idle = (exp_q.size() == 0) && (done_q.size() == 0);
      chk("busy", busy, !idle);
      chk("valid", fb_wr_valid, exp_q.size() != 0);
      if (exp_q.size() != 0 && fb_wr_valid) begin
        fr = exp_q[0];
        chk("addr", fb_wr_addr, fr.addr);
        chk("data", fb_wr_data, fr.data);
        chk("last", fb_wr_last, fr.last);
        if (fb_wr_ready) begin
          if (fr.last) done_q.push_back(cyc + 1);
          void'(exp_q.pop_front());
        end
      end
      if (clear_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          chk("done_cycle", cyc, done_q[0]);
          void'(done_q.pop_front());
        end
      end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
        chk("done_missing", 0, 1);
        void'(done_q.pop_front());
      end
      if (idle && clear_start) begin
        acc_cyc = cyc;
        for (int i = 0; i < N; i++)
          exp_q.push_back('{addr: 32'(i * STRIDE), data: {clear_color, clear_color}, last: (i == N - 1)});
      end
    end
  end

  int b_beats, b_bad, b_last_cnt, b_done_cnt, b_done_cyc;
  logic [31:0] b_last_addr;
  always @(negedge clk) begin
    if (!rst) begin
      if (b_valid) begin
        if (b_addr !== 32'(b_beats * 4) || b_data !== 32'h1234_1234) b_bad++;
        b_beats++;
        if (b_last) begin
          b_last_cnt++;
          b_last_addr = b_addr;
        end
      end
      if (b_done) begin
        b_done_cnt++;
        b_done_cyc = cyc;
      end
    end
  end

  task automatic start_clear(input logic [15:0] col);
    @(posedge clk); #1;
    clear_color = col;
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    clear_color = 16'($urandom);
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int n;
    for (n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && done_q.size() == 0 && !busy) begin
        clear_start = 1'b0;
        break;
      end
      if (rnd) begin
        fb_wr_ready = ($urandom_range(0, 3) != 0);
        clear_start = ($urandom_range(0, 7) == 0);
        clear_color = 16'($urandom);
      end
    end
    if (n == budget) chk("idle_timeout", 0, 1);
    fb_wr_ready = 1'b1;
    clear_start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_valid"}, fb_wr_valid, 0);
    chk({nm, "_busy"},  busy, 0);
    chk({nm, "_done"},  clear_done, 0);
    chk({nm, "_last"},  fb_wr_last, 0);
    chk({nm, "_addr"},  fb_wr_addr, 0);
    chk({nm, "_data"},  fb_wr_data, 0);
  endtask

  int d0, t0, n;

  initial begin
    rst = 1'b1; clear_start = 1'b0; clear_color = '0; fb_wr_ready = 1'b1;
    b_start = 1'b0; b_color = '0; b_ready = 1'b1;
    #2;
    check_reset_outputs("reset_initial");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic clear
    d0 = done_cnt;
    start_clear(16'hF800);
    wait_idle(50, 1'b0);
    chk("basic_done_latency", done_cyc, acc_cyc + 1 + N);
    chk("basic_done_count", done_cnt - d0, 1);

    // Backpressure: three stall cycles while the addr-8 beat is presented
    d0 = done_cnt;
    start_clear(16'hF800);
    repeat (2) @(posedge clk);
    #1 fb_wr_ready = 1'b0;
    chk("bp_addr8_presented", fb_wr_addr, 32'h8);
    repeat (3) @(posedge clk);
    #1 fb_wr_ready = 1'b1;
    wait_idle(50, 1'b0);
    chk("bp_done_latency", done_cyc, acc_cyc + 1 + N + 3);
    chk("bp_done_count", done_cnt - d0, 1);

    // Starts during WRITE and during the done cycle are ignored
    d0 = done_cnt;
    start_clear(16'hF800);
    clear_color = 16'h001F; clear_start = 1'b1;
    @(posedge clk); #1 clear_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 clear_start = 1'b1; clear_color = 16'h001F;
    chk("ign_in_done_cycle", clear_done, 1);
    @(posedge clk); #1 clear_start = 1'b0;
    chk("ign_not_restarted", busy, 0);
    wait_idle(50, 1'b0);
    chk("ign_done_count", done_cnt - d0, 1);

    // Reset mid-clear after the second beat, then a fresh clear from BASE
    d0 = done_cnt;
    start_clear(16'hABCD);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_midclear");
    exp_q.delete();
    done_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    chk("reset_no_done", done_cnt - d0, 0);
    start_clear(16'h07E0);
    wait_idle(50, 1'b0);
    chk("post_reset_done_count", done_cnt - d0, 1);

    // Randomized clears with random backpressure and stray starts
    for (int k = 0; k < 12; k++) begin
      start_clear(16'($urandom));
      wait_idle(300, 1'b1);
    end
    wait_idle(300, 1'b0);
    chk("scoreboard_drained", exp_q.size() + done_q.size(), 0);

    // Full default-size frame with ready held high
    @(posedge clk); #1 b_color = 16'h1234; b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0; b_color = 16'hFFFF;
    t0 = cyc;
    for (n = 0; n < 40000 && b_done_cnt == 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("big_done_seen", b_done_cnt, 1);
    chk("big_beats", b_beats, BIG_N);
    chk("big_bad_beats", b_bad, 0);
    chk("big_last_count", b_last_cnt, 1);
    chk("big_last_addr", b_last_addr, 32'h257FC);
    chk("big_done_cycle", b_done_cyc, t0 + BIG_N);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
